// File: rtl/calc_port_responder.sv
// Two-cycle calculator request responder (add/sub/shl/shr) with an in-order response FIFO.
// Latency: cmd at edge N, operand 2 at N+1, earliest response N+2; a full FIFO with no grant drops and flags it.
module calc_port_responder #(
    parameter int REQ_CMD_WIDTH  = 4,
    parameter int REQ_DATA_WIDTH = 32,
    parameter int REQ_TAG_WIDTH  = 2,
    parameter int OUT_RESP_WIDTH = 2,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                      ifClk,
    input  logic                      ifRst,
    input  logic [REQ_CMD_WIDTH-1:0]  ifReq_cmd_in,
    input  logic [REQ_DATA_WIDTH-1:0] ifReq_data_in,
    input  logic [REQ_TAG_WIDTH-1:0]  ifReq_tag_in,
    input  logic                      ifPort_grant,
    output logic [OUT_RESP_WIDTH-1:0] ifResp_out,
    output logic [REQ_DATA_WIDTH-1:0] ifData_out,
    output logic [REQ_TAG_WIDTH-1:0]  ifTag_out,
    output logic                      ifDrop_err,
    output logic                      ifBusy
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int SW = $clog2(REQ_DATA_WIDTH);

    localparam logic [REQ_CMD_WIDTH-1:0]  CMD_ADD  = REQ_CMD_WIDTH'(1);
    localparam logic [REQ_CMD_WIDTH-1:0]  CMD_SUB  = REQ_CMD_WIDTH'(2);
    localparam logic [REQ_CMD_WIDTH-1:0]  CMD_SHL  = REQ_CMD_WIDTH'(5);
    localparam logic [REQ_CMD_WIDTH-1:0]  CMD_SHR  = REQ_CMD_WIDTH'(6);
    localparam logic [OUT_RESP_WIDTH-1:0] RESP_OK  = OUT_RESP_WIDTH'(1);
    localparam logic [OUT_RESP_WIDTH-1:0] RESP_ERR = OUT_RESP_WIDTH'(2);

    typedef enum logic {ST_IDLE, ST_OP2} state_t;

    typedef struct packed {
        logic [OUT_RESP_WIDTH-1:0] resp;
        logic [REQ_DATA_WIDTH-1:0] data;
        logic [REQ_TAG_WIDTH-1:0]  tag;
    } rsp_t;

    state_t                    state_q, state_d;
    logic [REQ_CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [REQ_DATA_WIDTH-1:0] op1_q, op1_d;
    logic [REQ_TAG_WIDTH-1:0]  tag_q, tag_d;
    rsp_t                      fifo_q [RSP_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    rsp_t                      out_q, out_d;
    logic                      drop_q, drop_d, busy_q, busy_d;

    rsp_t                      result;
    logic [REQ_DATA_WIDTH:0]   sum;
    logic                      push_req, push, pop, full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Operand 2 is taken straight from the bus on the OP2 cycle.
    always_comb begin
        sum         = {1'b0, op1_q} + {1'b0, ifReq_data_in};
        result      = '0;
        result.tag  = tag_q;
        case (cmd_q)
            CMD_ADD: begin
                if (sum[REQ_DATA_WIDTH]) begin
                    result.resp = RESP_ERR;
                end else begin
                    result.resp = RESP_OK;
                    result.data = sum[REQ_DATA_WIDTH-1:0];
                end
            end
            CMD_SUB: begin
                if (op1_q < ifReq_data_in) begin
                    result.resp = RESP_ERR;
                end else begin
                    result.resp = RESP_OK;
                    result.data = op1_q - ifReq_data_in;
                end
            end
            CMD_SHL: begin
                result.resp = RESP_OK;
                result.data = op1_q << ifReq_data_in[SW-1:0];
            end
            CMD_SHR: begin
                result.resp = RESP_OK;
                result.data = op1_q >> ifReq_data_in[SW-1:0];
            end
            default: result.resp = RESP_ERR;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        op1_d    = op1_q;
        tag_d    = tag_q;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ifReq_cmd_in != '0) begin
                    cmd_d   = ifReq_cmd_in;
                    op1_d   = ifReq_data_in;
                    tag_d   = ifReq_tag_in;
                    state_d = ST_OP2;
                end
            end
            ST_OP2: begin
                push_req = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts when granted.
    always_comb begin
        full     = (count_q == CW'(RSP_DEPTH));
        pop      = (count_q != '0) && ifPort_grant;
        push     = push_req && (!full || pop);
        drop_d   = push_req && full && !pop;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        out_d  = pop ? fifo_q[rd_ptr_q] : '0;
        busy_d = (state_d == ST_OP2) || (count_d != '0);
    end

    always_ff @(posedge ifClk) begin
        if (ifRst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            op1_q    <= op1_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge ifClk) begin
        if (!ifRst && push) begin
            fifo_q[wr_ptr_q] <= result;
        end
    end

    assign ifResp_out = out_q.resp;
    assign ifData_out = out_q.data;
    assign ifTag_out  = out_q.tag;
    assign ifDrop_err = drop_q;
    assign ifBusy     = busy_q;
endmodule
